// File: rtl/word_stream_arbiter.sv
// -----------------------------------------------------------------------------
// word_stream_arbiter
//   Shares one character port between two sources (A and B). A source holds
//   the grant for a whole word, so words never interleave. Re-arbitration
//   happens only after a space (8'h20). If a word reaches MAX_WORD non-space
//   characters, a space is forced onto the stream and flagged with overflow.
//
// Ports
//   clk        system clock, all logic on posedge
//   reset      synchronous active-low reset
//   a_valid    source A offers a_char
//   a_char     source A character
//   a_ready    source A character accepted this cycle when a_valid & a_ready
//   b_valid    source B offers b_char
//   b_char     source B character
//   b_ready    source B character accepted this cycle when b_valid & b_ready
//   out_valid  one-cycle pulse: out_char is a new character
//   out_char   character forwarded downstream
//   out_src    owner of out_char (0 = A, 1 = B)
//   overflow   one-cycle pulse coinciding with a forced space
//   word_cnt   completed words, saturating at all-ones
// -----------------------------------------------------------------------------
module word_stream_arbiter #(
    parameter int MAX_WORD = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [7:0]       a_char,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [7:0]       b_char,
    output logic             b_ready,
    output logic             out_valid,
    output logic [7:0]       out_char,
    output logic             out_src,
    output logic             overflow,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int LEN_W = $clog2(MAX_WORD + 1);
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_A = 2'd1,
        GNT_B = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t             state_r, state_s;
    logic               owner_r, owner_s;
    logic               last_r, last_s;
    logic [LEN_W-1:0]   len_r, len_s;
    logic               out_valid_r, out_valid_s;
    logic [7:0]         out_char_r, out_char_s;
    logic               out_src_r, out_src_s;
    logic               overflow_r, overflow_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               word_done_s;
    logic               xfer_s;
    logic [7:0]         xchar_s;

    // Ready is a pure decode of the registered state.
    assign a_ready   = (state_r == GNT_A);
    assign b_ready   = (state_r == GNT_B);

    assign out_valid = out_valid_r;
    assign out_char  = out_char_r;
    assign out_src   = out_src_r;
    assign overflow  = overflow_r;
    assign word_cnt  = cnt_r;

    // Handshake of the granted source and its character.
    always_comb begin
        xfer_s  = 1'b0;
        xchar_s = 8'h00;
        if (state_r == GNT_A) begin
            xfer_s  = a_valid;
            xchar_s = a_char;
        end else if (state_r == GNT_B) begin
            xfer_s  = b_valid;
            xchar_s = b_char;
        end else begin
            xfer_s  = 1'b0;
            xchar_s = 8'h00;
        end
    end

    // Next-state, grant bookkeeping and next output values.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        last_s      = last_r;
        len_s       = len_r;
        out_valid_s = 1'b0;
        out_char_s  = out_char_r;
        out_src_s   = out_src_r;
        overflow_s  = 1'b0;
        word_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                // With both requesting, the source that did not own the last word wins.
                if (a_valid && b_valid) begin
                    owner_s = ~last_r;
                    state_s = last_r ? GNT_A : GNT_B;
                end else if (a_valid) begin
                    owner_s = 1'b0;
                    state_s = GNT_A;
                end else if (b_valid) begin
                    owner_s = 1'b1;
                    state_s = GNT_B;
                end else begin
                    state_s = IDLE;
                end
            end
            GNT_A, GNT_B: begin
                if (xfer_s) begin
                    out_valid_s = 1'b1;
                    out_char_s  = xchar_s;
                    out_src_s   = owner_r;
                    if (xchar_s == SPACE) begin
                        word_done_s = 1'b1;
                        last_s      = owner_r;
                        len_s       = LEN_W'(0);
                        state_s     = IDLE;
                    end else if (len_r == LEN_W'(MAX_WORD - 1)) begin
                        len_s   = len_r + LEN_W'(1);
                        state_s = FLUSH;
                    end else begin
                        len_s = len_r + LEN_W'(1);
                    end
                end else begin
                    state_s = state_r;
                end
            end
            FLUSH: begin
                // Forced space closes the over-long word; remaining chars start a new word.
                out_valid_s = 1'b1;
                out_char_s  = SPACE;
                out_src_s   = owner_r;
                overflow_s  = 1'b1;
                word_done_s = 1'b1;
                last_s      = owner_r;
                len_s       = LEN_W'(0);
                state_s     = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Saturating word counter.
    always_comb begin
        cnt_s = cnt_r;
        if (word_done_s && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            owner_r     <= 1'b0;
            last_r      <= 1'b1;
            len_r       <= LEN_W'(0);
            out_valid_r <= 1'b0;
            out_char_r  <= 8'h00;
            out_src_r   <= 1'b0;
            overflow_r  <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            last_r      <= last_s;
            len_r       <= len_s;
            out_valid_r <= out_valid_s;
            out_char_r  <= out_char_s;
            out_src_r   <= out_src_s;
            overflow_r  <= overflow_s;
            cnt_r       <= cnt_s;
        end
    end

endmodule

// File: tb/tb_word_stream_arbiter.sv
// -----------------------------------------------------------------------------
// tb_word_stream_arbiter
//   Two instances share the stimulus: dut (MAX_WORD=16, CNT_W=16) and
//   dut_s (MAX_WORD=4, CNT_W=2). sel picks which instance the handshake and
//   scoreboard follow. Source queues hold characters, with 9'h100 meaning
//   "valid low for one cycle".
// -----------------------------------------------------------------------------
module tb_word_stream_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        a_valid = 1'b0;
    logic [7:0]  a_char = 8'h00;
    logic        b_valid = 1'b0;
    logic [7:0]  b_char = 8'h00;
    logic        sel = 1'b0;

    logic        d_a_ready, d_b_ready, d_out_valid, d_out_src, d_overflow;
    logic [7:0]  d_out_char;
    logic [15:0] d_word_cnt;
    logic        s_a_ready, s_b_ready, s_out_valid, s_out_src, s_overflow;
    logic [7:0]  s_out_char;
    logic [1:0]  s_word_cnt;

    logic        m_a_ready, m_b_ready, m_out_valid, m_out_src, m_overflow;
    logic [7:0]  m_out_char;
    logic [15:0] m_word_cnt;

    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    logic [9:0]  exp_q[$];
    int          pulse_cyc[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    word_stream_arbiter #(.MAX_WORD(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_char(a_char), .a_ready(d_a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(d_b_ready),
        .out_valid(d_out_valid), .out_char(d_out_char), .out_src(d_out_src),
        .overflow(d_overflow), .word_cnt(d_word_cnt)
    );

    word_stream_arbiter #(.MAX_WORD(4), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_char(a_char), .a_ready(s_a_ready),
        .b_valid(b_valid), .b_char(b_char), .b_ready(s_b_ready),
        .out_valid(s_out_valid), .out_char(s_out_char), .out_src(s_out_src),
        .overflow(s_overflow), .word_cnt(s_word_cnt)
    );

    assign m_a_ready   = sel ? s_a_ready   : d_a_ready;
    assign m_b_ready   = sel ? s_b_ready   : d_b_ready;
    assign m_out_valid = sel ? s_out_valid : d_out_valid;
    assign m_out_src   = sel ? s_out_src   : d_out_src;
    assign m_overflow  = sel ? s_overflow  : d_overflow;
    assign m_out_char  = sel ? s_out_char  : d_out_char;
    assign m_word_cnt  = sel ? {14'd0, s_word_cnt} : d_word_cnt;

    task automatic push_src(input bit is_b, input string s);
        for (int i = 0; i < s.len(); i++) begin
            if (is_b) qb.push_back({1'b0, s[i]});
            else      qa.push_back({1'b0, s[i]});
        end
    endtask

    task automatic push_idle(input bit is_b, input int n);
        for (int i = 0; i < n; i++) begin
            if (is_b) qb.push_back(9'h100);
            else      qa.push_back(9'h100);
        end
    endtask

    task automatic push_exp(input bit ovf, input bit src, input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back({ovf, src, s[i]});
    endtask

    task automatic drive();
        logic [8:0] h;
        if (qa.size() != 0) begin
            h = qa[0];
            a_valid = (h != 9'h100);
            a_char  = h[7:0];
        end else begin
            a_valid = 1'b0;
            a_char  = 8'h00;
        end
        if (qb.size() != 0) begin
            h = qb[0];
            b_valid = (h != 9'h100);
            b_char  = h[7:0];
        end else begin
            b_valid = 1'b0;
            b_char  = 8'h00;
        end
    endtask

    // Drives the source queues and checks every output pulse against exp_q.
    // Entered and left at 1 time unit after a rising edge.
    task automatic run(input int max_cycles);
        int cyc;
        bit acc_a, acc_b;
        logic [9:0] e, got;
        cyc = 0;
        pulse_cyc.delete();
        drive();
        while ((qa.size() != 0 || qb.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            got = {m_overflow, m_out_src, m_out_char};
            if (m_out_valid) begin
                pulse_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_out: got %h expected no output (cycle %0d)", got, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_bad++;
                        $display("FAIL out_stream: got ovf/src/char %h expected %h (cycle %0d)", got, e, cyc);
                    end
                end
            end else if (m_overflow !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL overflow_idle: got %b expected 0 (cycle %0d)", m_overflow, cyc);
            end
            acc_a = a_valid && m_a_ready;
            acc_b = b_valid && m_b_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (qa.size() != 0 && (qa[0] == 9'h100 || acc_a)) void'(qa.pop_front());
            if (qb.size() != 0 && (qb[0] == 9'h100 || acc_b)) void'(qb.pop_front());
            drive();
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got %0d outputs pending expected 0", exp_q.size());
        end
        qa.delete();
        qb.delete();
        exp_q.delete();
        drive();
    endtask

    task automatic apply_reset();
        qa.delete();
        qb.delete();
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({d_a_ready, d_b_ready, d_out_valid, d_out_src, d_overflow} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags_d: got %b expected 00000", {d_a_ready, d_b_ready, d_out_valid, d_out_src, d_overflow});
        end
        n_cmp++;
        if (d_out_char !== 8'h00 || d_word_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_data_d: got char %h cnt %0d expected 00 0", d_out_char, d_word_cnt);
        end
        n_cmp++;
        if ({s_a_ready, s_b_ready, s_out_valid, s_out_src, s_overflow, s_out_char, s_word_cnt} !== 15'd0) begin
            n_bad++;
            $display("FAIL reset_s: got %h expected 0", {s_a_ready, s_b_ready, s_out_valid, s_out_src, s_overflow, s_out_char, s_word_cnt});
        end
    endtask

    task automatic test_single_word();
        sel = 1'b0;
        push_src(1'b0, "begin ");
        push_exp(1'b0, 1'b0, "begin ");
        run(40);
        n_cmp++;
        if (pulse_cyc.size() != 6 || pulse_cyc[0] != 2 || pulse_cyc[5] != 7) begin
            n_bad++;
            $display("FAIL single_timing: got %0d pulses first %0d expected 6 pulses at 2..7",
                     pulse_cyc.size(), (pulse_cyc.size() != 0) ? pulse_cyc[0] : -1);
        end
        n_cmp++;
        if (m_word_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL single_cnt: got %0d expected 1", m_word_cnt);
        end
    endtask

    task automatic test_both_valid();
        sel = 1'b0;
        apply_reset();
        push_src(1'b0, "end ");
        push_src(1'b1, "begin ");
        push_exp(1'b0, 1'b0, "end ");
        push_exp(1'b0, 1'b1, "begin ");
        run(60);
        n_cmp++;
        if (m_word_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL both_cnt: got %0d expected 2", m_word_cnt);
        end
    endtask

    task automatic test_stall();
        sel = 1'b0;
        push_src(1'b1, "be");
        push_idle(1'b1, 3);
        push_src(1'b1, "gin ");
        push_idle(1'b0, 3);
        push_src(1'b0, "x ");
        push_exp(1'b0, 1'b1, "begin ");
        push_exp(1'b0, 1'b0, "x ");
        run(60);
        n_cmp++;
        if (pulse_cyc.size() < 3 || pulse_cyc[2] - pulse_cyc[1] != 4) begin
            n_bad++;
            $display("FAIL stall_gap: got %0d pulses expected gap of 4 cycles between e and g", pulse_cyc.size());
        end
        n_cmp++;
        if (m_word_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL stall_cnt: got %0d expected 4", m_word_cnt);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        push_src(1'b0, "ab  c ");
        push_exp(1'b0, 1'b0, "ab  c ");
        run(60);
        n_cmp++;
        if (pulse_cyc.size() < 4 || pulse_cyc[3] - pulse_cyc[2] != 2) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d pulses expected one gap cycle after space", pulse_cyc.size());
        end
        n_cmp++;
        if (m_word_cnt !== 16'd7) begin
            n_bad++;
            $display("FAIL b2b_cnt: got %0d expected 7", m_word_cnt);
        end
    endtask

    task automatic test_fairness();
        sel = 1'b0;
        // Last word came from A, so B wins the first contested grant.
        push_src(1'b0, "a1 a2 ");
        push_src(1'b1, "b1 b2 ");
        push_exp(1'b0, 1'b1, "b1 ");
        push_exp(1'b0, 1'b0, "a1 ");
        push_exp(1'b0, 1'b1, "b2 ");
        push_exp(1'b0, 1'b0, "a2 ");
        run(80);
        n_cmp++;
        if (m_word_cnt !== 16'd11) begin
            n_bad++;
            $display("FAIL fair_cnt: got %0d expected 11", m_word_cnt);
        end
    endtask

    task automatic test_overflow();
        sel = 1'b1;
        apply_reset();
        push_src(1'b0, "abcdef ");
        push_exp(1'b0, 1'b0, "abcd");
        exp_q.push_back({1'b1, 1'b0, 8'h20});
        push_exp(1'b0, 1'b0, "ef ");
        run(60);
        n_cmp++;
        if (pulse_cyc.size() != 8 || pulse_cyc[4] - pulse_cyc[3] != 1 || pulse_cyc[5] - pulse_cyc[4] != 2) begin
            n_bad++;
            $display("FAIL ovf_timing: got %0d pulses expected 8 with forced space right after d", pulse_cyc.size());
        end
        n_cmp++;
        if (m_word_cnt !== 16'd2) begin
            n_bad++;
            $display("FAIL ovf_cnt: got %0d expected 2", m_word_cnt);
        end
    endtask

    task automatic test_reset_midword();
        sel = 1'b0;
        push_src(1'b0, "beg");
        push_exp(1'b0, 1'b0, "beg");
        run(40);
        apply_reset();
        n_cmp++;
        if ({d_a_ready, d_b_ready, d_out_valid, d_overflow, d_out_src, d_out_char} !== 13'd0 || d_word_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL midword_reset: got rdy %b%b v %b ovf %b char %h cnt %0d expected all 0",
                     d_a_ready, d_b_ready, d_out_valid, d_overflow, d_out_char, d_word_cnt);
        end
        push_src(1'b1, "ok ");
        push_exp(1'b0, 1'b1, "ok ");
        run(40);
        n_cmp++;
        if (pulse_cyc.size() != 3 || pulse_cyc[0] != 2) begin
            n_bad++;
            $display("FAIL midword_regrant: got %0d pulses expected 3 starting at cycle 2", pulse_cyc.size());
        end
        n_cmp++;
        if (m_word_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL midword_cnt: got %0d expected 1", m_word_cnt);
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp_cnt[5];
        exp_cnt[0] = 2'd1;
        exp_cnt[1] = 2'd2;
        exp_cnt[2] = 2'd3;
        exp_cnt[3] = 2'd3;
        exp_cnt[4] = 2'd3;
        sel = 1'b1;
        apply_reset();
        for (int w = 0; w < 5; w++) begin
            push_src(1'b0, "q ");
            push_exp(1'b0, 1'b0, "q ");
            run(20);
            n_cmp++;
            if (s_word_cnt !== exp_cnt[w]) begin
                n_bad++;
                $display("FAIL sat_cnt: got %0d expected %0d (word %0d)", s_word_cnt, exp_cnt[w], w);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_both_valid();
        test_stall();
        test_back_to_back();
        test_fairness();
        test_overflow();
        test_reset_midword();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
